// File: rtl/logic_unit_bist.sv
// logic_unit_bist -- exhaustive built-in self-test sequencer for the bitwise
// logic unit (F: 00 AND, 01 OR, 10 XOR, 11 NOR; data width W = 2*N).
//
// A start pulse sweeps the vector register v over every value in ascending
// order. Each vector takes two cycles: DRIVE lets the unit settle, and CHECK
// compares the returned Y with the internally computed expected value.
// Mismatches are counted in a saturating counter. done/pass hold the result
// until the next accepted start.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a run (accepted in IDLE or DONE only)
//   A, B, F         operands / function select driven to the logic unit
//   Y               result returned by the logic unit (combinational)
//   busy, done      run in progress / run complete
//   pass            done with zero errors
//   err_count       saturating mismatch count
//
// Optional feature (macro LBIST_FIRST_FAIL_EN): adds fail_valid, fail_A,
// fail_B, fail_F, fail_Y capturing the first mismatching vector of a run.
module logic_unit_bist #(
   parameter int N     = 2,
   parameter int ERR_W = 16,
   localparam int W    = 2*N,
   localparam int V    = 2*W + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [W-1:0]     A,
   output logic [W-1:0]     B,
   output logic [1:0]       F,
   input  logic [W-1:0]     Y,
   output logic             busy,
   output logic             done,
   output logic             pass,
`ifdef LBIST_FIRST_FAIL_EN
   output logic             fail_valid,
   output logic [W-1:0]     fail_A,
   output logic [W-1:0]     fail_B,
   output logic [1:0]       fail_F,
   output logic [W-1:0]     fail_Y,
`endif
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

   state_t           state_q, state_d;
   logic [V-1:0]     v;
   logic [W-1:0]     expected;
   logic             accept;
   logic             mismatch;
   logic             last_vec;

   // Operands come straight from register bits: no path from start to A/B/F.
   assign F = v[1:0];
   assign A = v[W+1:2];
   assign B = v[2*W+1:W+2];

   always_comb begin
      expected = '0;
      case (F)
         2'b00:   expected = A & B;
         2'b01:   expected = A | B;
         2'b10:   expected = A ^ B;
         default: expected = ~(A | B);
      endcase
   end

   assign accept   = start && (state_q == IDLE || state_q == FIN);
   assign last_vec = &v;
   assign mismatch = (state_q == CHECK) && (Y != expected);
   assign pass     = done && (err_count == '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, FIN: if (start) state_d = DRIVE;
         DRIVE:     state_d = CHECK;
         CHECK:     state_d = last_vec ? FIN : DRIVE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v         <= '0;
         err_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (accept) begin
         v         <= '0;
         err_count <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
      end else if (state_q == CHECK) begin
         if (mismatch && !(&err_count))
            err_count <= err_count + 1'b1;
         if (!last_vec) begin
            v <= v + 1'b1;
         end else begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

`ifdef LBIST_FIRST_FAIL_EN
   // Only the first mismatch of a run is kept; fail_valid blocks overwrites.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_valid <= 1'b0;
         fail_A     <= '0;
         fail_B     <= '0;
         fail_F     <= '0;
         fail_Y     <= '0;
      end else if (accept) begin
         fail_valid <= 1'b0;
         fail_A     <= '0;
         fail_B     <= '0;
         fail_F     <= '0;
         fail_Y     <= '0;
      end else if (mismatch && !fail_valid) begin
         fail_valid <= 1'b1;
         fail_A     <= A;
         fail_B     <= B;
         fail_F     <= F;
         fail_Y     <= Y;
      end
   end
`endif

endmodule

// File: tb/tb_logic_unit_bist.sv
// Bench for logic_unit_bist: two instances (ERR_W = 16 and ERR_W = 4) run in
// lockstep against a behavioural logic unit with an optional stuck-at bit.
module tb_logic_unit_bist;
   localparam int N = 2;
   localparam int W = 2*N;
   localparam int NVEC = 1 << (2*W + 2);

   logic clk = 1'b0;
   logic rst, start;
   logic [W-1:0] a16, b16, y16, a4, b4, y4;
   logic [1:0]   f16, f4;
   logic         busy16, done16, pass16, busy4, done4, pass4;
   logic [15:0]  err16;
   logic [3:0]   err4;
`ifdef LBIST_FIRST_FAIL_EN
   logic         fv16, fv4;
   logic [W-1:0] fa16, fb16, fy16, fa4, fb4, fy4;
   logic [1:0]   ff16, ff4;
`endif

   logic       fault_en;
   logic [1:0] fault_bit;
   logic       fault_val;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   logic_unit_bist #(.N(N), .ERR_W(16)) dut16 (
      .clk(clk), .rst(rst), .start(start), .A(a16), .B(b16), .F(f16), .Y(y16),
      .busy(busy16), .done(done16), .pass(pass16),
`ifdef LBIST_FIRST_FAIL_EN
      .fail_valid(fv16), .fail_A(fa16), .fail_B(fb16), .fail_F(ff16), .fail_Y(fy16),
`endif
      .err_count(err16));

   logic_unit_bist #(.N(N), .ERR_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .A(a4), .B(b4), .F(f4), .Y(y4),
      .busy(busy4), .done(done4), .pass(pass4),
`ifdef LBIST_FIRST_FAIL_EN
      .fail_valid(fv4), .fail_A(fa4), .fail_B(fb4), .fail_F(ff4), .fail_Y(fy4),
`endif
      .err_count(err4));

   function automatic logic [W-1:0] lu(input logic [W-1:0] a, b, input logic [1:0] f);
      case (f)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   function automatic logic [W-1:0] faulty(input logic [W-1:0] a, b, input logic [1:0] f);
      logic [W-1:0] r;
      r = lu(a, b, f);
      if (fault_en) r[fault_bit] = fault_val;
      return r;
   endfunction

   always_comb begin
      y16 = faulty(a16, b16, f16);
      y4  = faulty(a4, b4, f4);
   end

   // Reference: walk every (A,B,F) in index order, count faulty results,
   // remember the first failing index.
   function automatic void model(output int errs, output int first);
      logic [W-1:0] a, b;
      logic [1:0]   f;
      errs = 0; first = -1;
      for (int i = 0; i < NVEC; i++) begin
         f = 2'(i % 4); a = W'((i / 4) % 16); b = W'((i / 64) % 16);
         if (faulty(a, b, f) != lu(a, b, f)) begin
            errs++;
            if (first < 0) first = i;
         end
      end
   endfunction

   // Called #1 after an edge. Raises start, then follows the whole run,
   // checking the vector order and busy every cycle. Leaves at DONE entry.
   task automatic run(input bit hold);
      int bad = 0;
      int vi;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      tests++;
      if (err16 !== 16'd0 || err4 !== 4'd0 || done16 !== 1'b0) begin
         fails++;
         $display("FAIL accept_clear: err16=%0d err4=%0d done=%b, want 0 0 0", err16, err4, done16);
      end
      for (int c = 0; c < 2048; c++) begin
         vi = c / 2;
         if (f16 !== 2'(vi % 4) || a16 !== W'((vi / 4) % 16) || b16 !== W'((vi / 64) % 16) ||
             f4 !== f16 || a4 !== a16 || b4 !== b16 || busy16 !== 1'b1 || busy4 !== 1'b1 ||
             done16 !== 1'b0) begin
            if (bad == 0)
               $display("FAIL sequence: cycle %0d A=%h B=%h F=%b busy=%b, want A=%h B=%h F=%b busy=1",
                        c, a16, b16, f16, busy16, (vi / 4) % 16, (vi / 64) % 16, 2'(vi % 4));
            bad++;
         end
         if (hold && c == 2047) start = 1'b0;
         @(posedge clk); #1;
      end
      tests++;
      if (bad != 0) fails++;
      tests++;
      if (busy16 !== 1'b0 || done16 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b1) begin
         fails++;
         $display("FAIL run_end: busy=%b done=%b, want busy=0 done=1", busy16, done16);
      end
   endtask

   task automatic check_result(input string nm);
      int errs, first;
      int e4;
      model(errs, first);
      e4 = (errs > 15) ? 15 : errs;
      tests++;
      if (err16 !== 16'(errs) || pass16 !== (errs == 0)) begin
         fails++;
         $display("FAIL %s_err16: err=%0d pass=%b, want err=%0d pass=%b", nm, err16, pass16, errs, errs == 0);
      end
      tests++;
      if (err4 !== 4'(e4) || pass4 !== (errs == 0)) begin
         fails++;
         $display("FAIL %s_err4: err=%0d pass=%b, want err=%0d pass=%b", nm, err4, pass4, e4, errs == 0);
      end
`ifdef LBIST_FIRST_FAIL_EN
      tests++;
      if (first < 0) begin
         if (fv16 !== 1'b0 || fv4 !== 1'b0) begin
            fails++;
            $display("FAIL %s_fail_valid: got %b, want 0", nm, fv16);
         end
      end else begin
         logic [W-1:0] ea, eb;
         logic [1:0]   ef;
         ef = 2'(first % 4); ea = W'((first / 4) % 16); eb = W'((first / 64) % 16);
         if (fv16 !== 1'b1 || fa16 !== ea || fb16 !== eb || ff16 !== ef || fy16 !== faulty(ea, eb, ef) ||
             fv4 !== 1'b1 || fa4 !== ea || fy4 !== fy16) begin
            fails++;
            $display("FAIL %s_first_fail: v=%b A=%h B=%h F=%b Y=%h, want 1 %h %h %b %h",
                     nm, fv16, fa16, fb16, ff16, fy16, ea, eb, ef, faulty(ea, eb, ef));
         end
      end
`endif
   endtask

   task automatic test_reset;
      tests++;
      if (a16 !== '0 || b16 !== '0 || f16 !== 2'b00 || busy16 !== 1'b0 || done16 !== 1'b0 ||
          pass16 !== 1'b0 || err16 !== 16'd0 || busy4 !== 1'b0 || err4 !== 4'd0) begin
         fails++;
         $display("FAIL reset: A=%h B=%h F=%b busy=%b done=%b pass=%b err=%0d, want all 0",
                  a16, b16, f16, busy16, done16, pass16, err16);
      end
   endtask

   task automatic test_clean;
      fault_en = 1'b0;
      run(1'b0);
      check_result("clean");
   endtask

   task automatic test_stuck0;
      fault_en = 1'b1; fault_bit = 2'd0; fault_val = 1'b0;
      run(1'b0);
      tests++;
      if (err16 !== 16'd448 || err4 !== 4'd15) begin
         fails++;
         $display("FAIL stuck0_const: err16=%0d err4=%0d, want 448 15", err16, err4);
      end
      check_result("stuck0");
   endtask

   task automatic test_random_faults;
      for (int k = 0; k < 3; k++) begin
         fault_en  = 1'b1;
         fault_bit = 2'($urandom_range(0, 3));
         fault_val = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         run(1'b0);
         check_result("rand_fault");
      end
   endtask

   task automatic test_held_start;
      fault_en = 1'b1; fault_bit = 2'd0; fault_val = 1'b0;
      run(1'b1);
      check_result("held");
      @(posedge clk); #1;
      tests++;
      if (done16 !== 1'b1 || busy16 !== 1'b0) begin
         fails++;
         $display("FAIL no_restart: done=%b busy=%b, want 1 0", done16, busy16);
      end
      fault_en = 1'b0;
      run(1'b0);
      check_result("rerun");
   endtask

   task automatic test_reset_mid;
      fault_en = 1'b1; fault_bit = 2'd2; fault_val = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (100) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      tests++;
      if (a16 !== '0 || b16 !== '0 || f16 !== 2'b00 || busy16 !== 1'b0 || done16 !== 1'b0 ||
          err16 !== 16'd0 || busy4 !== 1'b0 || err4 !== 4'd0) begin
         fails++;
         $display("FAIL reset_mid: A=%h B=%h F=%b busy=%b done=%b err=%0d, want all 0",
                  a16, b16, f16, busy16, done16, err16);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      fault_en = 1'b0;
      @(posedge clk); #1;
      run(1'b0);
      check_result("after_reset");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      fault_en = 1'b0; fault_bit = 2'd0; fault_val = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      rst = 1'b0;
      @(posedge clk); #1;
      test_clean;
      test_stuck0;
      test_random_faults;
      test_held_start;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
